// File: rtl/aging_measure_sequencer_pkg.sv
// Shared widths and state encoding for the ring-oscillator aging measurement sequencer.
package aging_measure_sequencer_pkg;
  localparam int CNT_W   = 16;
  localparam int IDX_W   = 8;
  localparam int TIMER_W = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STRESS  = 3'd1,
    SETTLE  = 3'd2,
    CLEAR   = 3'd3,
    GATE    = 3'd4,
    CAPTURE = 3'd5
  } state_t;
endpackage

// File: rtl/phase_timer.sv
// Reusable phase down-counter: loaded on phase entry, done while the count sits at 1.
module phase_timer
  import aging_measure_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               srst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  output logic               done
);
  logic [TIMER_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - {{(TIMER_W-1){1'b0}}, 1'b1};
    end
  end

  assign done = (count_reg == {{(TIMER_W-1){1'b0}}, 1'b1});
endmodule

// File: rtl/aging_measure_sequencer.sv
// Sequences stress / settle / clear / gate / capture phases around a ring-oscillator counter.
module aging_measure_sequencer
  import aging_measure_sequencer_pkg::*;
#(
  parameter logic [TIMER_W-1:0] STRESS_CYCLES = 32'd50_000_000,
  parameter logic [TIMER_W-1:0] SETTLE_CYCLES = 32'd1000,
  parameter logic [TIMER_W-1:0] GATE_CYCLES   = 32'd1_000_000
) (
  input  logic             fpga_clk1,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             continuous,
  input  logic [CNT_W-1:0] cnt_value,
  output logic             Mode,
  output logic             Stress,
  output logic             cnt_clr,
  output logic             cnt_gate,
  output logic [CNT_W-1:0] value,
  output logic             valid,
  output logic             busy,
  output logic [IDX_W-1:0] meas_idx
);
  // A zero-length stress phase is skipped entirely rather than lasting one cycle.
  localparam state_t             FIRST_PHASE = (STRESS_CYCLES == '0) ? SETTLE : STRESS;
  localparam logic [TIMER_W-1:0] FIRST_LOAD  = (STRESS_CYCLES == '0) ? SETTLE_CYCLES : STRESS_CYCLES;

  state_t             state_reg;
  state_t             state_next;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_load_value;
  logic               timer_done;

  phase_timer u_phase_timer (
    .clk        (fpga_clk1),
    .srst       (rst),
    .load       (timer_load),
    .load_value (timer_load_value),
    .done       (timer_done)
  );

  always_comb begin
    state_next       = state_reg;
    timer_load       = 1'b0;
    timer_load_value = '0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_next       = FIRST_PHASE;
            timer_load       = 1'b1;
            timer_load_value = FIRST_LOAD;
          end
        end
        STRESS: begin
          if (timer_done) begin
            state_next       = SETTLE;
            timer_load       = 1'b1;
            timer_load_value = SETTLE_CYCLES;
          end
        end
        SETTLE: begin
          if (timer_done) state_next = CLEAR;
        end
        CLEAR: begin
          state_next       = GATE;
          timer_load       = 1'b1;
          timer_load_value = GATE_CYCLES;
        end
        GATE: begin
          if (timer_done) state_next = CAPTURE;
        end
        CAPTURE: begin
          if (continuous) begin
            state_next       = FIRST_PHASE;
            timer_load       = 1'b1;
            timer_load_value = FIRST_LOAD;
          end else begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs decode the upcoming state so they are registered and line up with it.
  always_ff @(posedge fpga_clk1) begin
    if (rst) begin
      state_reg <= IDLE;
      Stress    <= 1'b0;
      Mode      <= 1'b0;
      cnt_clr   <= 1'b0;
      cnt_gate  <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      value     <= '0;
      meas_idx  <= '0;
    end else begin
      state_reg <= state_next;
      Stress    <= (state_next == STRESS);
      Mode      <= (state_next inside {SETTLE, CLEAR, GATE, CAPTURE});
      cnt_clr   <= (state_next == CLEAR);
      cnt_gate  <= (state_next == GATE);
      busy      <= (state_next != IDLE);
      valid     <= 1'b0;
      if (state_reg == CAPTURE && !abort) begin
        value    <= cnt_value;
        valid    <= 1'b1;
        meas_idx <= meas_idx + {{(IDX_W-1){1'b0}}, 1'b1};
      end
    end
  end
endmodule

// File: tb/tb_aging_measure_sequencer.sv
// Directed bench: two instances (with and without stress phase) checked against a phase-offset model.
module tb_aging_measure_sequencer;
  localparam int T_SET = 2;
  localparam int G_CNT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        continuous = 1'b0;
  logic [15:0] cnt_value = 16'h0000;

  logic        mode_o[2], stress_o[2], clr_o[2], gate_o[2], valid_o[2], busy_o[2];
  logic [15:0] value_o[2];
  logic [7:0]  idx_o[2];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  aging_measure_sequencer #(.STRESS_CYCLES(32'd4), .SETTLE_CYCLES(32'd2), .GATE_CYCLES(32'd8)) dut_a (
    .fpga_clk1(clk), .rst(rst), .start(start), .abort(abort), .continuous(continuous),
    .cnt_value(cnt_value), .Mode(mode_o[0]), .Stress(stress_o[0]), .cnt_clr(clr_o[0]),
    .cnt_gate(gate_o[0]), .value(value_o[0]), .valid(valid_o[0]), .busy(busy_o[0]),
    .meas_idx(idx_o[0]));

  aging_measure_sequencer #(.STRESS_CYCLES(32'd0), .SETTLE_CYCLES(32'd2), .GATE_CYCLES(32'd8)) dut_b (
    .fpga_clk1(clk), .rst(rst), .start(start), .abort(abort), .continuous(continuous),
    .cnt_value(cnt_value), .Mode(mode_o[1]), .Stress(stress_o[1]), .cnt_clr(clr_o[1]),
    .cnt_gate(gate_o[1]), .value(value_o[1]), .valid(valid_o[1]), .busy(busy_o[1]),
    .meas_idx(idx_o[1]));

  function automatic int s_of(input int i);
    return (i == 0) ? 4 : 0;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, i, cyc, act, exp);
    end
  endtask

  // Model: a sequence is a run of P = S+T+G+2 cycles starting at m_t0; outputs follow from the offset.
  bit          m_active[2];
  int          m_t0[2];
  logic [15:0] m_value[2];
  logic [7:0]  m_idx[2];
  bit          m_valid[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      if (rst) begin
        m_active[i] = 1'b0;
        m_value[i]  = 16'h0;
        m_idx[i]    = 8'h0;
      end else if (abort) begin
        m_active[i] = 1'b0;
      end else if (!m_active[i]) begin
        if (start) begin
          m_active[i] = 1'b1;
          m_t0[i]     = cyc + 1;
        end
      end else if (cyc - m_t0[i] == s_of(i) + T_SET + G_CNT + 1) begin
        m_value[i] = cnt_value;
        m_idx[i]   = m_idx[i] + 8'd1;
        m_valid[i] = 1'b1;
        if (continuous) m_t0[i] = cyc + 1;
        else m_active[i] = 1'b0;
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    int o, s;
    bit a;
    if (cyc >= 1) begin
      for (int i = 0; i < 2; i++) begin
        a = m_active[i];
        o = cyc - m_t0[i];
        s = s_of(i);
        chk("stress", i, 32'(stress_o[i]), 32'(a && o < s));
        chk("mode",   i, 32'(mode_o[i]),   32'(a && o >= s && o < s + T_SET + G_CNT + 2));
        chk("clr",    i, 32'(clr_o[i]),    32'(a && o == s + T_SET));
        chk("gate",   i, 32'(gate_o[i]),   32'(a && o > s + T_SET && o <= s + T_SET + G_CNT));
        chk("busy",   i, 32'(busy_o[i]),   32'(a));
        chk("valid",  i, 32'(valid_o[i]),  32'(m_valid[i]));
        chk("value",  i, 32'(value_o[i]),  32'(m_value[i]));
        chk("idx",    i, 32'(idx_o[i]),    32'(m_idx[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic pulse_start(input int c);
    go_to(c);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    bit seen_wrap;
    logic [7:0] prev;

    // Reset
    step(); step();
    chk("rst_value", 0, 32'(value_o[0]), 32'h0);
    chk("rst_idx",   0, 32'(idx_o[0]),   32'h0);
    chk("rst_busy",  1, 32'(busy_o[1]),  32'h0);
    rst = 1'b0;
    $display("test reset done at cyc %0d", cyc);

    // Single shot
    c = cyc + 2;
    cnt_value = 16'h1234;
    pulse_start(c);
    go_to(c + 4);  chk("lit_stress4", 0, 32'(stress_o[0]), 32'h1);
    go_to(c + 5);  chk("lit_stress5", 0, 32'(stress_o[0]), 32'h0);
                   chk("lit_mode5",   0, 32'(mode_o[0]),   32'h1);
    go_to(c + 7);  chk("lit_clr7",    0, 32'(clr_o[0]),    32'h1);
    go_to(c + 13); chk("lit_valid13", 1, 32'(valid_o[1]),  32'h1);
                   chk("lit_value13", 1, 32'(value_o[1]),  32'h1234);
    go_to(c + 16); chk("lit_valid16", 0, 32'(valid_o[0]),  32'h0);
    go_to(c + 17); chk("lit_valid17", 0, 32'(valid_o[0]),  32'h1);
                   chk("lit_value17", 0, 32'(value_o[0]),  32'h1234);
                   chk("lit_idx17",   0, 32'(idx_o[0]),    32'h1);
                   chk("lit_busy17",  0, 32'(busy_o[0]),   32'h0);
    go_to(c + 20);
    $display("test single_shot done at cyc %0d", cyc);

    // Continuous, three back-to-back sequences
    c = cyc + 2;
    continuous = 1'b1;
    pulse_start(c);
    for (int k = 1; k <= 48; k++) begin
      go_to(c + k);
      cnt_value = 16'(cyc * 37);
      if (k == 40) continuous = 1'b0;
      if (k == 17) chk("lit_nogap17", 0, 32'(busy_o[0]), 32'h1);
      if (k == 33) begin
        chk("lit_cvalid33", 0, 32'(valid_o[0]), 32'h1);
        chk("lit_cidx33",   0, 32'(idx_o[0]),   32'h3);
      end
    end
    go_to(c + 49);
    chk("lit_cvalid49", 0, 32'(valid_o[0]), 32'h1);
    chk("lit_cidx49",   0, 32'(idx_o[0]),   32'h4);
    go_to(c + 52);
    $display("test continuous done at cyc %0d", cyc);

    // Abort in GATE, then a full sequence
    c = cyc + 2;
    pulse_start(c);
    go_to(c + 10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("lit_abort_gate", 0, 32'(gate_o[0]), 32'h0);
    chk("lit_abort_busy", 0, 32'(busy_o[0]), 32'h0);
    chk("lit_abort_idx",  0, 32'(idx_o[0]),  32'h4);
    pulse_start(c + 13);
    go_to(c + 30);
    chk("lit_rerun_idx",  0, 32'(idx_o[0]),  32'h5);
    go_to(c + 32);
    $display("test abort_gate done at cyc %0d", cyc);

    // Start held through STRESS; then start+abort together in IDLE
    c = cyc + 2;
    go_to(c);
    start = 1'b1;
    go_to(c + 4);
    start = 1'b0;
    go_to(c + 17);
    chk("lit_held_idx", 0, 32'(idx_o[0]), 32'h6);
    go_to(c + 20);
    start = 1'b1;
    abort = 1'b1;
    step(); step();
    start = 1'b0;
    abort = 1'b0;
    chk("lit_sa_busy", 0, 32'(busy_o[0]), 32'h0);
    chk("lit_sa_busy", 1, 32'(busy_o[1]), 32'h0);
    go_to(c + 25);
    $display("test start_held done at cyc %0d", cyc);

    // Abort coinciding with CAPTURE
    c = cyc + 2;
    pulse_start(c);
    go_to(c + 16);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("lit_capabort_valid", 0, 32'(valid_o[0]), 32'h0);
    chk("lit_capabort_idx",   0, 32'(idx_o[0]),   32'h6);
    go_to(c + 20);
    $display("test abort_capture done at cyc %0d", cyc);

    // meas_idx wrap over 256 measurements
    seen_wrap = 1'b0;
    prev = idx_o[0];
    continuous = 1'b1;
    pulse_start(cyc + 1);
    for (int k = 0; k < 300 * 16 && !seen_wrap; k++) begin
      step();
      if (valid_o[0] === 1'b1) begin
        if (prev == 8'hFF) begin
          chk("lit_wrap", 0, 32'(idx_o[0]), 32'h0);
          seen_wrap = 1'b1;
        end
        prev = idx_o[0];
      end
    end
    chk("lit_wrap_seen", 0, 32'(seen_wrap), 32'h1);
    continuous = 1'b0;
    go_to(cyc + 20);
    $display("test wrap done at cyc %0d", cyc);

    // Reset mid-sequence
    c = cyc + 2;
    pulse_start(c);
    go_to(c + 9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("lit_mrst_value", 0, 32'(value_o[0]), 32'h0);
    chk("lit_mrst_idx",   0, 32'(idx_o[0]),   32'h0);
    chk("lit_mrst_busy",  0, 32'(busy_o[0]),  32'h0);
    chk("lit_mrst_mode",  0, 32'(mode_o[0]),  32'h0);
    chk("lit_mrst_gate",  0, 32'(gate_o[0]),  32'h0);
    go_to(c + 30);
    $display("test mid_reset done at cyc %0d", cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/aging_measure_sequencer.md
AGING_MEASURE_SEQUENCER -- requirements
Module: aging_measure_sequencer

Interface
REQ-001 The block SHALL have the parameter STRESS_CYCLES, default 32'd50_000_000, giving the stress phase length in clocks; 0 skips the stress phase.
REQ-002 The block SHALL have the parameter SETTLE_CYCLES, default 32'd1000, giving the settle length in clocks; the minimum is 1.
REQ-003 The block SHALL have the parameter GATE_CYCLES, default 32'd1_000_000, giving the count-window length in clocks; the minimum is 1.
REQ-004 The block SHALL have the port fpga_clk1, input, 1 bit: the sole clock; all logic is on its rising edge.
REQ-005 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have the port start, input, 1 bit: level sampled each clock; it starts a sequence when the block is idle.
REQ-007 The block SHALL have the port abort, input, 1 bit: returns the block to idle.
REQ-008 The block SHALL have the port continuous, input, 1 bit: when 1, the sequence repeats without a new start.
REQ-009 The block SHALL have the port cnt_value, input, 16 bits: running edge count from the ring-oscillator counter.
REQ-010 The block SHALL have the port Mode, output, 1 bit: ring-oscillator measurement-mode enable.
REQ-011 The block SHALL have the port Stress, output, 1 bit: ring-oscillator stress enable.
REQ-012 The block SHALL have the port cnt_clr, output, 1 bit: one-cycle counter clear.
REQ-013 The block SHALL have the port cnt_gate, output, 1 bit: counter enable window.
REQ-014 The block SHALL have the port value, output, 16 bits: last captured count, held until the next capture.
REQ-015 The block SHALL have the port valid, output, 1 bit: one-cycle pulse when value updates.
REQ-016 The block SHALL have the port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-017 The block SHALL have the port meas_idx, output, 8 bits: completed-measurement count.

Function
REQ-018 The state machine SHALL have the states IDLE, STRESS, SETTLE, CLEAR, GATE and CAPTURE, held in a registered state.
REQ-019 In IDLE, start=1 with abort=0 SHALL move the state to STRESS on the next cycle, or to SETTLE if STRESS_CYCLES=0.
REQ-020 STRESS SHALL last exactly STRESS_CYCLES cycles with Stress=1 and Mode=0.
REQ-021 SETTLE SHALL last exactly SETTLE_CYCLES cycles with Stress=0 and Mode=1.
REQ-022 CLEAR SHALL last 1 cycle with cnt_clr=1 and Mode=1.
REQ-023 GATE SHALL last exactly GATE_CYCLES cycles with cnt_gate=1 and Mode=1.
REQ-024 CAPTURE SHALL last 1 cycle with Mode=1; on the following clock edge, value<=cnt_value, valid=1 for one cycle, and meas_idx increments, wrapping 255->0.
REQ-025 After CAPTURE, the next state SHALL be STRESS (or SETTLE if STRESS_CYCLES=0) when continuous=1, and IDLE otherwise.
REQ-026 Latency SHALL be as follows: with start sampled in cycle N, valid is high in cycle N+STRESS_CYCLES+SETTLE_CYCLES+GATE_CYCLES+3.
REQ-027 start SHALL be ignored whenever the state is not IDLE; no queuing occurs.
REQ-028 abort=1 in any state SHALL force IDLE on the next cycle, with Stress, Mode, cnt_gate and cnt_clr all 0 from that cycle onward.
REQ-029 An abort SHALL leave value and meas_idx unchanged and SHALL produce no valid pulse.
REQ-030 abort arriving in the same cycle as CAPTURE SHALL suppress the capture.
REQ-031 start and abort both high in IDLE SHALL resolve in favour of abort, so the state remains IDLE.
REQ-032 Stress and Mode SHALL never both be 1, and SHALL be driven directly from registers so that they are glitch-free.
REQ-033 Phase timers SHALL be 32-bit down-counters, loaded on phase entry, with the phase exit taken when the count reaches 1.
REQ-034 A change in continuous SHALL take effect only at the CAPTURE decision.

Reset
REQ-035 On rst=1 at a clock edge, the block SHALL set state=IDLE, value=16'h0000, valid=0, meas_idx=8'h00, busy=0, Stress=0, Mode=0, cnt_clr=0, cnt_gate=0, and timer=0.
REQ-036 rst SHALL take priority over start and abort.
REQ-037 Reset asserted mid-sequence SHALL produce no valid pulse.

Structure
REQ-038 A shared package SHALL hold the state encoding, the 16-bit count width, the 8-bit index width, and the 32-bit timer width.
REQ-039 The timer SHALL be one sub-module, phase_timer, with load, load_value, and done=(count==1) outputs, and one instance of it shall be reused across phases.
REQ-040 The parameters SHALL be overridable at instantiation, and benches shall use small values.

Verification (STRESS_CYCLES=4, SETTLE_CYCLES=2, GATE_CYCLES=8, start in cycle 0)
REQ-041 Single shot: cnt_value=16'h1234 during CAPTURE -> Stress is high in cycles 1-4, Mode in 5-16, cnt_clr in cycle 7, cnt_gate in 8-15, valid only in cycle 17 with value=16'h1234 and meas_idx=1, then busy=0 from cycle 17.
REQ-042 Continuous: continuous=1 with 3 full sequences -> valid appears every 16 cycles, meas_idx runs 1,2,3, and there is no idle gap.
REQ-043 Abort in GATE cycle 10 -> cnt_gate=0 and busy=0 at cycle 11, no valid, and value and meas_idx unchanged; a new start afterwards runs a full sequence.
REQ-044 Start held high during STRESS, with start and abort together in IDLE -> no restart and no state change, respectively.
REQ-045 STRESS_CYCLES=0 -> Stress is never asserted and valid occurs in cycle 13.
REQ-046 256 completed measurements -> meas_idx wraps to 8'h00; rst in cycle 9 -> all outputs are at their reset values in cycle 10 and no valid pulse occurs.
